// File: rtl/frame_buf_pkg.sv
// Shared constants and types for the THz frame buffer and its reader/writer sides.
package frame_buf_pkg;
  localparam int NUM_FRAMES    = 30;
  localparam int PIX_PER_FRAME = 8;
  localparam int DATA_W        = 10;
  localparam int PADDR_W       = 4;
  localparam int FRAME_W       = 5;
  localparam int PIX_W         = 3;
  localparam int TIMEOUT       = 7;
  localparam int TMR_W         = 3;

  typedef enum logic [2:0] {
    RD_IDLE,
    RD_REQ,
    RD_WAIT,
    RD_OUT,
    RD_DONE
  } rd_state_t;

  // Frame index wraps at the buffer depth, not at the field width.
  function automatic logic [FRAME_W-1:0] next_frame(input logic [FRAME_W-1:0] f);
    return (f == FRAME_W'(NUM_FRAMES - 1)) ? '0 : f + 1'b1;
  endfunction
endpackage

// File: rtl/frame_buf_reader.sv
// Read-side sequencer: walks a frame range, pulses the buffer read port once per
// pixel and streams the returned samples downstream with framing flags.
//
//   state   | meaning
//   --------+-----------------------------------------------------------
//   RD_IDLE | waiting for start; validates the command
//   RD_REQ  | buf_read_en high for exactly one cycle
//   RD_WAIT | waiting for buf_valid, timeout down-counter running
//   RD_OUT  | sample held on m_* until m_ready
//   RD_DONE | one-cycle done pulse, then back to idle
module frame_buf_reader
  import frame_buf_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [FRAME_W-1:0] start_frame,
  input  logic [FRAME_W-1:0] num_frames,
  input  logic               abort,
  output logic               busy,
  output logic               done,
  output logic               err,
  output logic               buf_read_en,
  output logic [FRAME_W-1:0] buf_frame_read_sel,
  output logic [PIX_W-1:0]   buf_pixel_index_out,
  input  logic [DATA_W-1:0]  buf_pixel_data,
  input  logic [PADDR_W-1:0] buf_pixel_addr,
  input  logic               buf_valid,
  output logic               m_valid,
  input  logic               m_ready,
  output logic [DATA_W-1:0]  m_data,
  output logic [PADDR_W-1:0] m_addr,
  output logic [FRAME_W-1:0] m_frame,
  output logic [PIX_W-1:0]   m_index,
  output logic               m_sof,
  output logic               m_eof,
  output logic               m_last
);

  rd_state_t          state;
  logic [FRAME_W-1:0] frame;
  logic [FRAME_W-1:0] remaining;
  logic [PIX_W-1:0]   pix;
  logic [TMR_W-1:0]   tmr;
  logic               cmd_ok;
  logic               last_pix;

  assign cmd_ok = (start_frame < FRAME_W'(NUM_FRAMES)) &&
                  (num_frames != '0) &&
                  (num_frames <= FRAME_W'(NUM_FRAMES));
  assign last_pix = (pix == PIX_W'(PIX_PER_FRAME - 1));

  // The frame/pixel counters are registers, so the buffer selects are registered too.
  assign buf_frame_read_sel  = frame;
  assign buf_pixel_index_out = pix;

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= RD_IDLE;
      frame       <= '0;
      remaining   <= '0;
      pix         <= '0;
      tmr         <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      err         <= 1'b0;
      buf_read_en <= 1'b0;
      m_valid     <= 1'b0;
      m_data      <= '0;
      m_addr      <= '0;
      m_frame     <= '0;
      m_index     <= '0;
      m_sof       <= 1'b0;
      m_eof       <= 1'b0;
      m_last      <= 1'b0;
    end else begin
      done        <= 1'b0;
      buf_read_en <= 1'b0;
      case (state)
        RD_IDLE: begin
          if (start) begin
            if (cmd_ok) begin
              err         <= 1'b0;
              frame       <= start_frame;
              pix         <= '0;
              remaining   <= num_frames;
              busy        <= 1'b1;
              buf_read_en <= 1'b1;
              state       <= RD_REQ;
            end else begin
              err  <= 1'b1;
              done <= 1'b1;
            end
          end
        end
        RD_REQ: begin
          tmr   <= TMR_W'(TIMEOUT - 1);
          state <= RD_WAIT;
        end
        RD_WAIT: begin
          if (buf_valid) begin
            m_data  <= buf_pixel_data;
            m_addr  <= buf_pixel_addr;
            m_frame <= frame;
            m_index <= pix;
            m_sof   <= (pix == '0);
            m_eof   <= last_pix;
            m_last  <= last_pix && (remaining == FRAME_W'(1));
            m_valid <= 1'b1;
            state   <= RD_OUT;
          end else if (tmr == '0) begin
            err   <= 1'b1;
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= RD_DONE;
          end else begin
            tmr <= tmr - 1'b1;
          end
        end
        RD_OUT: begin
          if (m_ready) begin
            m_valid <= 1'b0;
            if (m_last) begin
              busy  <= 1'b0;
              done  <= 1'b1;
              state <= RD_DONE;
            end else begin
              pix <= pix + 1'b1;
              if (last_pix) begin
                frame     <= next_frame(frame);
                remaining <= remaining - 1'b1;
              end
              buf_read_en <= 1'b1;
              state       <= RD_REQ;
            end
          end
        end
        RD_DONE: state <= RD_IDLE;
        default: state <= RD_IDLE;
      endcase

      // Abort overrides whatever the active state decided, including a same-cycle handshake.
      if (abort && (state inside {RD_REQ, RD_WAIT, RD_OUT})) begin
        m_valid     <= 1'b0;
        buf_read_en <= 1'b0;
        busy        <= 1'b0;
        done        <= 1'b1;
        state       <= RD_DONE;
      end
    end
  end

endmodule

// File: tb/tb_frame_buf_reader.sv
// Bench for frame_buf_reader: behavioural buffer model, expected-beat queue and
// a negedge monitor for handshakes, stall stability and read_en spacing.
module tb_frame_buf_reader;
  import frame_buf_pkg::*;

  logic               clk = 1'b0;
  logic               rst = 1'b1;
  logic               start = 1'b0;
  logic [FRAME_W-1:0] start_frame = '0;
  logic [FRAME_W-1:0] num_frames = '0;
  logic               abort = 1'b0;
  logic               busy, done, err, buf_read_en;
  logic [FRAME_W-1:0] buf_frame_read_sel;
  logic [PIX_W-1:0]   buf_pixel_index_out;
  logic [DATA_W-1:0]  buf_pixel_data = '0;
  logic [PADDR_W-1:0] buf_pixel_addr = '0;
  logic               buf_valid = 1'b0;
  logic               m_valid;
  logic               m_ready = 1'b0;
  logic [DATA_W-1:0]  m_data;
  logic [PADDR_W-1:0] m_addr;
  logic [FRAME_W-1:0] m_frame;
  logic [PIX_W-1:0]   m_index;
  logic               m_sof, m_eof, m_last;

  frame_buf_reader dut (
    .clk(clk), .rst(rst), .start(start), .start_frame(start_frame),
    .num_frames(num_frames), .abort(abort), .busy(busy), .done(done), .err(err),
    .buf_read_en(buf_read_en), .buf_frame_read_sel(buf_frame_read_sel),
    .buf_pixel_index_out(buf_pixel_index_out), .buf_pixel_data(buf_pixel_data),
    .buf_pixel_addr(buf_pixel_addr), .buf_valid(buf_valid), .m_valid(m_valid),
    .m_ready(m_ready), .m_data(m_data), .m_addr(m_addr), .m_frame(m_frame),
    .m_index(m_index), .m_sof(m_sof), .m_eof(m_eof), .m_last(m_last)
  );

  always #5 clk = ~clk;

  int          tests_run = 0;
  int          tests_failed = 0;
  logic [24:0] sb[$];
  int          reads = 0;
  int          ready_mode = 0;
  bit          suppress_en = 1'b0;
  int          suppress_pix = 0;

  function automatic logic [DATA_W-1:0] data_of(input int f, input int p);
    return DATA_W'(f * 8 + p);
  endfunction

  function automatic logic [PADDR_W-1:0] addr_of(input int f, input int p);
    return PADDR_W'((f * 3 + p) % 16);
  endfunction

  function automatic logic [24:0] beat(input int f, input int p, input bit last);
    return {data_of(f, p), addr_of(f, p), FRAME_W'(f), PIX_W'(p),
            (p == 0), (p == PIX_PER_FRAME - 1), last};
  endfunction

  // Buffer model: data appears on the second cycle after the read_en cycle.
  logic               s1_v = 1'b0;
  logic [FRAME_W-1:0] s1_f = '0;
  logic [PIX_W-1:0]   s1_p = '0;
  always @(posedge clk) begin
    s1_v           <= buf_read_en && !(suppress_en && int'(buf_pixel_index_out) == suppress_pix);
    s1_f           <= buf_frame_read_sel;
    s1_p           <= buf_pixel_index_out;
    buf_valid      <= s1_v;
    buf_pixel_data <= data_of(int'(s1_f), int'(s1_p));
    buf_pixel_addr <= addr_of(int'(s1_f), int'(s1_p));
  end

  always @(posedge clk) begin
    #1;
    case (ready_mode)
      1: m_ready = 1'b1;
      2: m_ready = ($urandom_range(0, 99) < 30);
      3: m_ready = !(m_valid && m_index == 3'd2);
      default: ;
    endcase
  end

  logic        prev_rd = 1'b0;
  logic        prev_stall = 1'b0;
  logic [24:0] prev_beat = '0;
  logic [24:0] exp_beat;
  wire  [24:0] cur_beat = {m_data, m_addr, m_frame, m_index, m_sof, m_eof, m_last};

  always @(negedge clk) begin
    if (rst) begin
      prev_rd    = 1'b0;
      prev_stall = 1'b0;
    end else begin
      if (buf_read_en) reads++;
      if (prev_rd) begin
        tests_run++;
        if (buf_read_en !== 1'b0) begin
          tests_failed++;
          $display("FAIL read_en_spacing: read_en=%b, required 0 after a read cycle", buf_read_en);
        end
      end
      if (prev_stall) begin
        tests_run++;
        if (m_valid !== 1'b1 || cur_beat !== prev_beat) begin
          tests_failed++;
          $display("FAIL stall_hold: valid=%b beat=%h, required valid=1 beat=%h", m_valid, cur_beat, prev_beat);
        end
      end
      if (m_valid && m_ready && !abort) begin
        tests_run++;
        if (sb.size() == 0) begin
          tests_failed++;
          $display("FAIL beat_extra: got beat %h, no beat expected", cur_beat);
        end else begin
          exp_beat = sb.pop_front();
          if (cur_beat !== exp_beat) begin
            tests_failed++;
            $display("FAIL beat_data: got %h, required %h", cur_beat, exp_beat);
          end
        end
      end
      prev_rd    = buf_read_en;
      prev_stall = m_valid && !m_ready && !abort;
      prev_beat  = cur_beat;
    end
  end

  task automatic push_job(input int sf, input int nf);
    int f = sf;
    for (int k = 0; k < nf; k++) begin
      for (int p = 0; p < PIX_PER_FRAME; p++) sb.push_back(beat(f, p, (k == nf - 1) && (p == 7)));
      f = (f + 1) % NUM_FRAMES;
    end
  endtask

  task automatic pulse_start(input int sf, input int nf);
    @(posedge clk); #1;
    start_frame = FRAME_W'(sf);
    num_frames  = FRAME_W'(nf);
    start       = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_done(input int limit, output int done_n, output int last_rd);
    done_n  = -1;
    last_rd = -1;
    for (int n = 1; n <= limit; n++) begin
      @(negedge clk);
      if (buf_read_en) last_rd = n;
      if (done) begin
        done_n = n;
        break;
      end
    end
    tests_run++;
    if (done_n < 0) begin
      tests_failed++;
      $display("FAIL done_timeout: no done within %0d cycles", limit);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    tests_run++;
    if ({busy, done, err, buf_read_en, m_valid, m_sof, m_eof, m_last} !== 8'h00) begin
      tests_failed++;
      $display("FAIL reset_flags: got %b, required 00000000",
               {busy, done, err, buf_read_en, m_valid, m_sof, m_eof, m_last});
    end
    tests_run++;
    if ({m_data, m_addr, m_frame, m_index, buf_frame_read_sel, buf_pixel_index_out} !== '0) begin
      tests_failed++;
      $display("FAIL reset_data: got %h, required 0",
               {m_data, m_addr, m_frame, m_index, buf_frame_read_sel, buf_pixel_index_out});
    end
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic test_single_frame();
    int dn, lr, r0;
    ready_mode = 1;
    m_ready    = 1'b1;
    r0 = reads;
    push_job(3, 1);
    pulse_start(3, 1);
    wait_done(200, dn, lr);
    tests_run++;
    if (dn != 1 + 4 * 8) begin
      tests_failed++;
      $display("FAIL single_latency: done at cycle %0d, required %0d", dn, 1 + 4 * 8);
    end
    tests_run++;
    if (sb.size() != 0 || reads - r0 != 8) begin
      tests_failed++;
      $display("FAIL single_count: pending=%0d reads=%0d, required 0 and 8", sb.size(), reads - r0);
    end
    tests_run++;
    if (err !== 1'b0 || busy !== 1'b0) begin
      tests_failed++;
      $display("FAIL single_status: err=%b busy=%b, required 0 0", err, busy);
    end
    @(negedge clk);
    tests_run++;
    if (done !== 1'b0) begin
      tests_failed++;
      $display("FAIL done_pulse_width: done=%b, required 0", done);
    end
  endtask

  task automatic test_wrap();
    int dn, lr, r0;
    ready_mode = 1;
    r0 = reads;
    push_job(28, 3);
    pulse_start(28, 3);
    wait_done(400, dn, lr);
    tests_run++;
    if (dn != 1 + 4 * 24) begin
      tests_failed++;
      $display("FAIL wrap_latency: done at cycle %0d, required %0d", dn, 1 + 4 * 24);
    end
    tests_run++;
    if (sb.size() != 0 || reads - r0 != 24) begin
      tests_failed++;
      $display("FAIL wrap_count: pending=%0d reads=%0d, required 0 and 24", sb.size(), reads - r0);
    end
  endtask

  task automatic test_random_ready();
    int dn, lr, r0;
    ready_mode = 2;
    r0 = reads;
    push_job(10, 2);
    pulse_start(10, 2);
    wait_done(5000, dn, lr);
    tests_run++;
    if (sb.size() != 0 || reads - r0 != 16 || err !== 1'b0) begin
      tests_failed++;
      $display("FAIL random_count: pending=%0d reads=%0d err=%b, required 0 16 0", sb.size(), reads - r0, err);
    end
    ready_mode = 1;
  endtask

  task automatic test_bad_cmd();
    int sfs[3] = '{0, 30, 5};
    int nfs[3] = '{0, 1, 31};
    int dn, lr, r0;
    ready_mode = 1;
    for (int i = 0; i < 3; i++) begin
      r0 = reads;
      pulse_start(sfs[i], nfs[i]);
      wait_done(10, dn, lr);
      tests_run++;
      if (dn != 1 || err !== 1'b1 || busy !== 1'b0) begin
        tests_failed++;
        $display("FAIL bad_cmd_%0d: done_cycle=%0d err=%b busy=%b, required 1 1 0", i, dn, err, busy);
      end
      repeat (3) @(negedge clk);
      tests_run++;
      if (reads != r0 || busy !== 1'b0 || done !== 1'b0 || err !== 1'b1) begin
        tests_failed++;
        $display("FAIL bad_cmd_idle_%0d: reads=%0d busy=%b done=%b err=%b, required 0 0 0 1",
                 i, reads - r0, busy, done, err);
      end
    end
  endtask

  task automatic test_timeout();
    int dn, lr, r0;
    ready_mode   = 1;
    suppress_en  = 1'b1;
    suppress_pix = 5;
    r0 = reads;
    for (int p = 0; p < 5; p++) sb.push_back(beat(2, p, 1'b0));
    pulse_start(2, 1);
    wait_done(200, dn, lr);
    tests_run++;
    if (err !== 1'b1 || dn - lr != TIMEOUT + 1) begin
      tests_failed++;
      $display("FAIL timeout_err: err=%b read_to_done=%0d, required 1 and %0d", err, dn - lr, TIMEOUT + 1);
    end
    repeat (10) @(negedge clk);
    tests_run++;
    if (reads - r0 != 6 || sb.size() != 0 || busy !== 1'b0) begin
      tests_failed++;
      $display("FAIL timeout_reads: reads=%0d pending=%0d busy=%b, required 6 0 0", reads - r0, sb.size(), busy);
    end
    suppress_en = 1'b0;
  endtask

  task automatic test_abort();
    int dn, lr, r0;
    bit seen;
    ready_mode = 3;
    r0 = reads;
    sb.push_back(beat(1, 0, 1'b0));
    sb.push_back(beat(1, 1, 1'b0));
    pulse_start(1, 1);
    seen = 1'b0;
    for (int n = 0; n < 100; n++) begin
      @(negedge clk);
      if (m_valid && m_index == 3'd2) begin
        seen = 1'b1;
        break;
      end
    end
    tests_run++;
    if (!seen) begin
      tests_failed++;
      $display("FAIL abort_reach: pixel 2 beat not seen, required within 100 cycles");
    end
    repeat (3) @(posedge clk);
    @(posedge clk); #1;
    ready_mode = 0;
    m_ready    = 1'b1;
    abort      = 1'b1;
    @(negedge clk);
    tests_run++;
    if (m_valid !== 1'b1) begin
      tests_failed++;
      $display("FAIL abort_hold: m_valid=%b, required 1 in the abort cycle", m_valid);
    end
    @(posedge clk); #1;
    abort = 1'b0;
    @(negedge clk);
    tests_run++;
    if (m_valid !== 1'b0 || done !== 1'b1 || busy !== 1'b0) begin
      tests_failed++;
      $display("FAIL abort_end: valid=%b done=%b busy=%b, required 0 1 0", m_valid, done, busy);
    end
    @(negedge clk);
    tests_run++;
    if (done !== 1'b0 || sb.size() != 0 || reads - r0 != 3) begin
      tests_failed++;
      $display("FAIL abort_after: done=%b pending=%0d reads=%0d, required 0 0 3", done, sb.size(), reads - r0);
    end
    ready_mode = 1;
    push_job(0, 1);
    pulse_start(0, 1);
    wait_done(200, dn, lr);
    tests_run++;
    if (err !== 1'b0 || dn != 33 || sb.size() != 0) begin
      tests_failed++;
      $display("FAIL restart: err=%b done_cycle=%0d pending=%0d, required 0 33 0", err, dn, sb.size());
    end
  endtask

  initial begin
    test_reset();
    test_single_frame();
    test_wrap();
    test_random_ready();
    test_bad_cmd();
    test_timeout();
    test_abort();
    repeat (5) @(posedge clk);
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation exceeded time limit, required completion");
    $fatal(1, "watchdog");
  end

endmodule
